// File: rtl/scene_renderer.sv
// scene_renderer: 640x480 VGA timing plus a 3-tick rasteriser for three platforms and the player.
// Optional macro BG_GRID_EN overlays a grey 16-unit grid on background pixels.
module scene_renderer #(
  parameter int SQ_WIDTH     = 41,
  parameter int PLAYER_WIDTH = 24,
  parameter int PIX_DIV      = 4,
  parameter int SCALE_SFT    = 1,
  parameter int H_VIS        = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_VIS        = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SQ_WIDTH-1:0]     square1,
  input  logic [SQ_WIDTH-1:0]     square2,
  input  logic [SQ_WIDTH-1:0]     square3,
  input  logic [PLAYER_WIDTH-1:0] player,
  output logic [7:0]              rgb,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    blank,
  output logic                    frame_start
);

  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  // Returns {hit, colour index}; outline wins over face, side lies strictly below the outline.
  function automatic logic [3:0] sq_hit(input logic [SQ_WIDTH-1:0] sq,
                                        input logic signed [9:0] lx,
                                        input logic signed [9:0] ly);
    logic signed [9:0] cx, cy, r, h, dx, dy, adx, ady;
    cx  = {2'b00, sq[40:33]};
    cy  = {2'b00, sq[32:25]};
    r   = {2'b00, sq[24:17]};
    h   = {2'b00, sq[16:9]};
    dx  = lx - cx;
    dy  = ly - cy;
    adx = dx[9] ? -dx : dx;
    ady = dy[9] ? -dy : dy;
    sq_hit = 4'b0000;
    if (adx <= r && ady <= r && (adx == r || ady == r)) sq_hit = {1'b1, sq[2:0]};
    else if (adx < r && ady < r)                         sq_hit = {1'b1, sq[8:6]};
    else if (adx <= r && dy > r && dy <= r + h)          sq_hit = {1'b1, sq[5:3]};
  endfunction

  function automatic logic pl_hit(input logic [PLAYER_WIDTH-1:0] pl,
                                  input logic signed [9:0] lx,
                                  input logic signed [9:0] ly);
    logic signed [9:0] px, py, ph, dx;
    px = {2'b00, pl[23:16]};
    py = {2'b00, pl[15:8]};
    ph = {2'b00, pl[7:0]};
    dx = lx - px;
    pl_hit = (dx >= -10'sd1) && (dx <= 10'sd1) && (ly >= py - ph) && (ly <= py);
  endfunction

  function automatic logic [7:0] palette(input logic [2:0] idx);
    case (idx)
      3'd1:    palette = 8'hE0;
      3'd2:    palette = 8'h1C;
      3'd3:    palette = 8'h03;
      3'd4:    palette = 8'hFC;
      3'd5:    palette = 8'h1F;
      3'd6:    palette = 8'hE3;
      3'd7:    palette = 8'hFF;
      default: palette = 8'h00;
    endcase
  endfunction

  logic [DIV_W-1:0]        div_q, div_d;
  logic [9:0]              hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic [SQ_WIDTH-1:0]     sq1_q, sq1_d, sq2_q, sq2_d, sq3_q, sq3_d;
  logic [PLAYER_WIDTH-1:0] pl_q, pl_d;
  logic                    fs_q, fs_d;
  logic signed [9:0]       lx_q, lx_d, ly_q, ly_d;
  logic                    hs1_q, hs1_d, vs1_q, vs1_d, bl1_q, bl1_d;
  logic [2:0]              idx_q, idx_d;
  logic                    hs2_q, hs2_d, vs2_q, vs2_d, bl2_q, bl2_d;
  logic [7:0]              rgb_q, rgb_d;
  logic                    hs3_q, hs3_d, vs3_q, vs3_d, bl3_q, bl3_d;
  logic                    tick;
  logic [3:0]              h1, h2, h3;
`ifdef BG_GRID_EN
  logic                    grid_q, grid_d;
`endif

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    div_d  = tick ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    sq1_d  = sq1_q;
    sq2_d  = sq2_q;
    sq3_d  = sq3_q;
    pl_d   = pl_q;
    fs_d   = 1'b0;
    if (tick) begin
      hcnt_d = (hcnt_q == H_LAST) ? 10'd0 : hcnt_q + 10'd1;
      if (hcnt_q == H_LAST) vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      // Shadow load at the first blanked line so a whole frame sees one descriptor set.
      if (hcnt_q == 10'd0 && vcnt_q == V_VIS_C) begin
        sq1_d = square1;
        sq2_d = square2;
        sq3_d = square3;
        pl_d  = player;
        fs_d  = 1'b1;
      end
    end
  end

  always_comb begin
    h1 = sq_hit(sq1_q, lx_q, ly_q);
    h2 = sq_hit(sq2_q, lx_q, ly_q);
    h3 = sq_hit(sq3_q, lx_q, ly_q);
    lx_d = lx_q;   ly_d = ly_q;
    hs1_d = hs1_q; vs1_d = vs1_q; bl1_d = bl1_q;
    idx_d = idx_q;
    hs2_d = hs2_q; vs2_d = vs2_q; bl2_d = bl2_q;
    rgb_d = rgb_q;
    hs3_d = hs3_q; vs3_d = vs3_q; bl3_d = bl3_q;
`ifdef BG_GRID_EN
    grid_d = grid_q;
`endif
    if (tick) begin
      lx_d  = hcnt_q >> SCALE_SFT;
      ly_d  = vcnt_q >> SCALE_SFT;
      hs1_d = !(hcnt_q >= HS_START && hcnt_q < HS_END);
      vs1_d = !(vcnt_q >= VS_START && vcnt_q < VS_END);
      bl1_d = (hcnt_q >= H_VIS_C) || (vcnt_q >= V_VIS_C);
      // Lowest priority first so later assignments override.
      idx_d = 3'd0;
      if (h3[3]) idx_d = h3[2:0];
      if (h2[3]) idx_d = h2[2:0];
      if (h1[3]) idx_d = h1[2:0];
      if (pl_hit(pl_q, lx_q, ly_q)) idx_d = 3'd7;
      hs2_d = hs1_q; vs2_d = vs1_q; bl2_d = bl1_q;
`ifdef BG_GRID_EN
      grid_d = (lx_q[3:0] == 4'd0) || (ly_q[3:0] == 4'd0);
`endif
      rgb_d = palette(idx_q);
`ifdef BG_GRID_EN
      if (idx_q == 3'd0 && grid_q) rgb_d = 8'h49;
`endif
      if (bl2_q) rgb_d = 8'h00;
      hs3_d = hs2_q; vs3_d = vs2_q; bl3_d = bl2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;  hcnt_q <= '0;  vcnt_q <= '0;
      sq1_q <= '0;  sq2_q <= '0;   sq3_q <= '0;  pl_q <= '0;  fs_q <= 1'b0;
      lx_q  <= '0;  ly_q  <= '0;   hs1_q <= 1'b1; vs1_q <= 1'b1; bl1_q <= 1'b1;
      idx_q <= '0;  hs2_q <= 1'b1; vs2_q <= 1'b1; bl2_q <= 1'b1;
      rgb_q <= '0;  hs3_q <= 1'b1; vs3_q <= 1'b1; bl3_q <= 1'b1;
`ifdef BG_GRID_EN
      grid_q <= 1'b0;
`endif
    end else begin
      div_q <= div_d;  hcnt_q <= hcnt_d; vcnt_q <= vcnt_d;
      sq1_q <= sq1_d;  sq2_q <= sq2_d;   sq3_q <= sq3_d;  pl_q <= pl_d;  fs_q <= fs_d;
      lx_q  <= lx_d;   ly_q  <= ly_d;    hs1_q <= hs1_d;  vs1_q <= vs1_d; bl1_q <= bl1_d;
      idx_q <= idx_d;  hs2_q <= hs2_d;   vs2_q <= vs2_d;  bl2_q <= bl2_d;
      rgb_q <= rgb_d;  hs3_q <= hs3_d;   vs3_q <= vs3_d;  bl3_q <= bl3_d;
`ifdef BG_GRID_EN
      grid_q <= grid_d;
`endif
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hs3_q;
  assign vsync       = vs3_q;
  assign blank       = bl3_q;
  assign frame_start = fs_q;

endmodule
